// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - pipeline event counters, run-termination FSM and counter read port
// Optional PERF_SATURATE_EN: counters saturate at all-ones and raise a sticky ovf_o.
module pipe_perf_monitor #(
  parameter int CNT_W       = 32,
  parameter int CYCLE_LIMIT = 30,
  parameter int IDLE_LIMIT  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic             flush_i,
  input  logic             retire_i,
  input  logic             rd_req_i,
  input  logic [1:0]       rd_sel_i,
  output logic             rd_ack_o,
  output logic [CNT_W-1:0] rd_data_o,
  output logic [1:0]       state_o,
  output logic             done_o,
  output logic             ovf_o
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_HALT = 2'b10;

  localparam int             IW       = (IDLE_LIMIT > 0) ? $clog2(IDLE_LIMIT + 1) : 1;
  localparam logic [CNT_W-1:0] CYC_LIM  = CNT_W'(CYCLE_LIMIT);
  localparam logic [IW-1:0]    IDLE_LIM = IW'(IDLE_LIMIT);

  logic [1:0]       state;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt, ret_cnt;
  logic [CNT_W-1:0] cyc_nxt, stall_nxt, flush_nxt, ret_nxt;
  logic [IW-1:0]    idle_cnt, idle_nxt;
  logic [CNT_W-1:0] rd_mux;
  logic             stall_inc;
  logic             halt;

  // A stall that coincides with a resolving branch is branch-induced, not a hazard stall.
  assign stall_inc = stall_i && !branch_i;

`ifdef PERF_SATURATE_EN
  logic ovf_q;
  logic ovf_hit;
`endif

  always_comb begin
    cyc_nxt   = cyc_cnt + CNT_W'(1);
    stall_nxt = stall_cnt + CNT_W'(stall_inc);
    flush_nxt = flush_cnt + CNT_W'(flush_i);
    ret_nxt   = ret_cnt + CNT_W'(retire_i);
`ifdef PERF_SATURATE_EN
    ovf_hit = 1'b0;
    if (&cyc_cnt) begin
      cyc_nxt = cyc_cnt;
      ovf_hit = 1'b1;
    end
    if (stall_inc && (&stall_cnt)) begin
      stall_nxt = stall_cnt;
      ovf_hit   = 1'b1;
    end
    if (flush_i && (&flush_cnt)) begin
      flush_nxt = flush_cnt;
      ovf_hit   = 1'b1;
    end
    if (retire_i && (&ret_cnt)) begin
      ret_nxt = ret_cnt;
      ovf_hit = 1'b1;
    end
`endif
  end

  always_comb begin
    idle_nxt = idle_cnt;
    if (retire_i)
      idle_nxt = '0;
    else if (idle_cnt != IDLE_LIM)
      idle_nxt = idle_cnt + IW'(1);
  end

  always_comb begin
    halt = !start_i;
    if ((CYCLE_LIMIT != 0) && (cyc_nxt == CYC_LIM))
      halt = 1'b1;
    if ((IDLE_LIMIT != 0) && (idle_nxt == IDLE_LIM))
      halt = 1'b1;
  end

  always_comb begin
    case (rd_sel_i)
      2'd0:    rd_mux = cyc_cnt;
      2'd1:    rd_mux = stall_cnt;
      2'd2:    rd_mux = flush_cnt;
      default: rd_mux = ret_cnt;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      cyc_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      ret_cnt   <= '0;
      idle_cnt  <= '0;
      rd_ack_o  <= 1'b0;
      rd_data_o <= '0;
`ifdef PERF_SATURATE_EN
      ovf_q     <= 1'b0;
`endif
    end else begin
      // Read captures the pre-update counter values of this edge.
      rd_ack_o <= rd_req_i;
      if (rd_req_i)
        rd_data_o <= rd_mux;
      case (state)
        S_IDLE: begin
          if (start_i)
            state <= S_RUN;
        end
        S_RUN: begin
          if (start_i) begin
            cyc_cnt   <= cyc_nxt;
            stall_cnt <= stall_nxt;
            flush_cnt <= flush_nxt;
            ret_cnt   <= ret_nxt;
            idle_cnt  <= idle_nxt;
`ifdef PERF_SATURATE_EN
            if (ovf_hit)
              ovf_q <= 1'b1;
`endif
          end
          if (halt)
            state <= S_HALT;
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;
  assign done_o  = (state == S_HALT);

`ifdef PERF_SATURATE_EN
  assign ovf_o = ovf_q;
`else
  assign ovf_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - directed self-checking bench for pipe_perf_monitor
module tb_pipe_perf_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stall, branch, flush, retire;
  logic        rd_req;
  logic [1:0]  rd_sel;
  logic        rd_ack;
  logic [31:0] rd_data;
  logic [1:0]  state;
  logic        done;
  logic        ovf;

  logic        start_b, retire_b, rd_req_b;
  logic [1:0]  rd_sel_b;
  logic        rd_ack_b;
  logic [3:0]  rd_data_b;
  logic [1:0]  state_b;
  logic        done_b;
  logic        ovf_b;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_perf_monitor dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall), .branch_i(branch),
    .flush_i(flush), .retire_i(retire), .rd_req_i(rd_req), .rd_sel_i(rd_sel),
    .rd_ack_o(rd_ack), .rd_data_o(rd_data), .state_o(state), .done_o(done), .ovf_o(ovf)
  );

  pipe_perf_monitor #(.CNT_W(4), .CYCLE_LIMIT(0), .IDLE_LIMIT(8)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start_b), .stall_i(1'b0), .branch_i(1'b0),
    .flush_i(1'b0), .retire_i(retire_b), .rd_req_i(rd_req_b), .rd_sel_i(rd_sel_b),
    .rd_ack_o(rd_ack_b), .rd_data_o(rd_data_b), .state_o(state_b), .done_o(done_b), .ovf_o(ovf_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 0; stall = 0; branch = 0; flush = 0; retire = 0;
    rd_req = 0; rd_sel = 0; start_b = 0; retire_b = 0; rd_req_b = 0; rd_sel_b = 0;
    @(negedge clk);
    do_reset();
    check("reset_state", 32'(state), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    check("reset_ack", 32'(rd_ack), 32'd0);
    check("reset_data", rd_data, 32'd0);

    // Cycle limit: retire every cycle, halt 30 edges after entering RUN.
    start = 1; retire = 1;
    tick();
    check("enter_run", 32'(state), 32'd1);
    repeat (29) tick();
    check("run_at_29", 32'(state), 32'd1);
    tick();
    check("halt_at_30", 32'(state), 32'd2);
    check("done_at_30", 32'(done), 32'd1);
    repeat (3) tick();
    check("halt_absorbing", 32'(state), 32'd2);
    rd_req = 1; rd_sel = 0;
    tick();
    check("cyc_ack", 32'(rd_ack), 32'd1);
    check("cyc_30", rd_data, 32'd30);
    rd_sel = 3;
    tick();
    check("ret_ack", 32'(rd_ack), 32'd1);
    check("ret_30", rd_data, 32'd30);
    rd_req = 0; rd_sel = 2;
    tick();
    check("ack_low", 32'(rd_ack), 32'd0);
    check("data_hold", rd_data, 32'd30);

    // Stall/flush pattern, back-to-back reads, mid-run reset.
    do_reset();
    tick();
    check("run2_enter", 32'(state), 32'd1);
    stall = 1; branch = 0;
    repeat (3) tick();
    branch = 1;
    repeat (2) tick();
    stall = 0; branch = 0; flush = 1;
    repeat (2) tick();
    flush = 0;
    rd_req = 1; rd_sel = 0;
    tick();
    check("b2b_ack0", 32'(rd_ack), 32'd1);
    check("b2b_cyc7", rd_data, 32'd7);
    rd_sel = 1;
    tick();
    check("b2b_ack1", 32'(rd_ack), 32'd1);
    check("b2b_stall3", rd_data, 32'd3);
    rd_sel = 2;
    tick();
    check("b2b_ack2", 32'(rd_ack), 32'd1);
    check("b2b_flush2", rd_data, 32'd2);
    rd_sel = 3;
    tick();
    check("b2b_ack3", 32'(rd_ack), 32'd1);
    check("b2b_ret10", rd_data, 32'd10);
    rd_req = 0;
    tick();
    check("b2b_ack_end", 32'(rd_ack), 32'd0);
    check("b2b_hold", rd_data, 32'd10);
    do_reset();
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_data", rd_data, 32'd0);
    check("midrst_ack", 32'(rd_ack), 32'd0);
    tick();
    check("midrst_rerun", 32'(state), 32'd1);
    tick();
    rd_req = 1; rd_sel = 0;
    tick();
    rd_req = 0;
    check("midrst_cyc1", rd_data, 32'd1);

    // Idle limit: 5 retires then none, halt on the 8th idle edge.
    do_reset();
    tick();
    repeat (5) tick();
    retire = 0;
    repeat (7) tick();
    check("idle_run_7", 32'(state), 32'd1);
    tick();
    check("idle_halt", 32'(state), 32'd2);
    rd_req = 1; rd_sel = 0;
    tick();
    check("idle_cyc13", rd_data, 32'd13);
    rd_sel = 3;
    tick();
    check("idle_ret5", rd_data, 32'd5);
    rd_req = 0; start = 0;

    // Narrow counter: 20 run edges at CNT_W=4.
    do_reset();
    start_b = 1; retire_b = 1;
    tick();
    repeat (15) tick();
    check("narrow_ovf15", 32'(ovf_b), 32'd0);
    tick();
`ifdef PERF_SATURATE_EN
    check("narrow_ovf16", 32'(ovf_b), 32'd1);
`else
    check("narrow_ovf16", 32'(ovf_b), 32'd0);
`endif
    repeat (4) tick();
    start_b = 0;
    tick();
    check("narrow_halt", 32'(state_b), 32'd2);
    rd_req_b = 1; rd_sel_b = 0;
    tick();
    rd_req_b = 0;
`ifdef PERF_SATURATE_EN
    check("narrow_cyc", 32'(rd_data_b), 32'd15);
    check("narrow_ovf_end", 32'(ovf_b), 32'd1);
`else
    check("narrow_cyc", 32'(rd_data_b), 32'd4);
    check("narrow_ovf_end", 32'(ovf_b), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
